// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus iterative 32-step MUL/DIVU/REMU,
// registering results into the EX/MEM latch and stalling upstream while busy.
module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] pc_in,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [31:0] sign_extend,
    input  logic [4:0]  rd,
    input  logic [3:0]  alu_op,
    input  logic        alu_src,
    input  logic        flush,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [31:0] branch_target_out,
    output logic        zero_out,
    output logic [4:0]  rd_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [31:0] op_b;
    logic [31:0] single_result;
    logic [31:0] branch_target;
    logic        is_iter;

    // Iterative datapath: it_a is multiplier / dividend-quotient shift register,
    // it_b is multiplicand / divisor, it_acc is product / partial remainder.
    logic [31:0] it_a, it_b, it_acc;
    logic [31:0] it_target, it_store;
    logic [4:0]  it_rd;
    logic [3:0]  it_op;
    logic [32:0] div_trial, div_diff;
    logic        div_fits;
    logic [31:0] iter_result;

    always_comb begin
        op_b          = alu_src ? sign_extend : dataB;
        is_iter       = (alu_op == 4'd11) || (alu_op == 4'd12) || (alu_op == 4'd13);
        branch_target = pc_in + {sign_extend[29:0], 2'b00};
        single_result = '0;
        case (alu_op)
            4'd0:    single_result = dataA + op_b;
            4'd1:    single_result = dataA - op_b;
            4'd2:    single_result = dataA & op_b;
            4'd3:    single_result = dataA | op_b;
            4'd4:    single_result = dataA ^ op_b;
            4'd5:    single_result = ~(dataA | op_b);
            4'd6:    single_result = {31'd0, $signed(dataA) < $signed(op_b)};
            4'd7:    single_result = {31'd0, dataA < op_b};
            4'd8:    single_result = op_b << dataA[4:0];
            4'd9:    single_result = op_b >> dataA[4:0];
            4'd10:   single_result = $signed(op_b) >>> dataA[4:0];
            default: single_result = '0;
        endcase
    end

    // Restoring division: borrow out of the 33-bit trial subtract means "does not fit".
    always_comb begin
        div_trial   = {it_acc, it_a[31]};
        div_diff    = div_trial - {1'b0, it_b};
        div_fits    = ~div_diff[32];
        iter_result = (it_op == 4'd12) ? it_a : it_acc;
    end

    always_comb begin
        stall = ~reset && (((state == IDLE) && in_valid && is_iter) || (state == BUSY));
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid && is_iter) state_next = BUSY;
                BUSY:    if (cnt == 5'd31) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            it_a              <= '0;
            it_b              <= '0;
            it_acc            <= '0;
            it_target         <= '0;
            it_store          <= '0;
            it_rd             <= '0;
            it_op             <= '0;
            valid_out         <= 1'b0;
            alu_result_out    <= '0;
            store_data_out    <= '0;
            branch_target_out <= '0;
            zero_out          <= 1'b0;
            rd_out            <= '0;
        end else begin
            state <= state_next;
            if (flush) begin
                valid_out <= 1'b0;
                cnt       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid && is_iter) begin
                            it_a      <= dataA;
                            it_b      <= op_b;
                            it_acc    <= '0;
                            it_target <= branch_target;
                            it_store  <= dataB;
                            it_rd     <= rd;
                            it_op     <= alu_op;
                            cnt       <= '0;
                            valid_out <= 1'b0;
                        end else if (in_valid) begin
                            valid_out         <= 1'b1;
                            alu_result_out    <= single_result;
                            zero_out          <= (single_result == '0);
                            store_data_out    <= dataB;
                            branch_target_out <= branch_target;
                            rd_out            <= rd;
                        end else begin
                            valid_out <= 1'b0;
                        end
                    end
                    BUSY: begin
                        cnt       <= cnt + 5'd1;
                        valid_out <= 1'b0;
                        if (it_op == 4'd11) begin
                            if (it_a[0]) it_acc <= it_acc + it_b;
                            it_b <= it_b << 1;
                            it_a <= it_a >> 1;
                        end else begin
                            it_acc <= div_fits ? div_diff[31:0] : div_trial[31:0];
                            it_a   <= {it_a[30:0], div_fits};
                        end
                    end
                    DONE: begin
                        valid_out         <= 1'b1;
                        alu_result_out    <= iter_result;
                        zero_out          <= (iter_result == '0);
                        store_data_out    <= it_store;
                        branch_target_out <= it_target;
                        rd_out            <= it_rd;
                    end
                    default: valid_out <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, alu_src, flush;
    logic [31:0] pc_in, dataA, dataB, sign_extend;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        stall, valid_out, zero_out;
    logic [31:0] alu_result_out, store_data_out, branch_target_out;
    logic [4:0]  rd_out;

    int tests = 0;
    int fails = 0;

    execute_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc_in(pc_in),
        .dataA(dataA), .dataB(dataB), .sign_extend(sign_extend), .rd(rd),
        .alu_op(alu_op), .alu_src(alu_src), .flush(flush), .stall(stall),
        .valid_out(valid_out), .alu_result_out(alu_result_out),
        .store_data_out(store_data_out), .branch_target_out(branch_target_out),
        .zero_out(zero_out), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] se, input logic src,
                         input logic [4:0] r, input logic [31:0] pc);
        in_valid = v; alu_op = op; dataA = a; dataB = b;
        sign_extend = se; alu_src = src; rd = r; pc_in = pc;
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        drive(1'b1, op, a, b, 32'd0, 1'b0, 5'd3, 32'd0);
        settle();
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        step();
        check(tag, alu_result_out, exp);
        check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    endtask

    // Presents an iterative op at T and walks it to T+34, leaving inputs unchanged.
    task automatic run_iter(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic src, input logic [4:0] r,
                            input logic [31:0] exp);
        int stall_cycles;
        drive(1'b1, op, a, src ? 32'd0 : b, src ? b : 32'd0, src, r, 32'h40);
        settle();
        check({tag, "_stall_T"}, {31'd0, stall}, 32'd1);
        stall_cycles = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            settle();
            check({tag, "_bubble"}, {31'd0, valid_out}, 32'd0);
            if (stall) stall_cycles++;
            else break;
        end
        check({tag, "_stall_len"}, stall_cycles, 32'd33);
        step();
        check(tag, alu_result_out, exp);
        check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
        check({tag, "_rd"}, {27'd0, rd_out}, {27'd0, r});
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b1, 4'd11, 32'd3, 32'd5, 32'd0, 1'b0, 5'd1, 32'd0);
        settle();
        check("reset_stall", {31'd0, stall}, 32'd0);
        step();
        step();
        check("reset_valid", {31'd0, valid_out}, 32'd0);
        check("reset_result", alu_result_out, 32'd0);
        check("reset_btarget", branch_target_out, 32'd0);
        check("reset_rd", {27'd0, rd_out}, 32'd0);

        reset = 1'b0;
        drive(1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd7, 32'd0);
        settle();
        check("add_stall", {31'd0, stall}, 32'd0);
        step();
        check("add_result", alu_result_out, 32'h8000_0000);
        check("add_valid", {31'd0, valid_out}, 32'd1);
        check("add_zero", {31'd0, zero_out}, 32'd0);
        check("add_rd", {27'd0, rd_out}, 32'd7);
        check("add_store", store_data_out, 32'd1);

        drive(1'b1, 4'd1, 32'd5, 32'd5, 32'hFFFF_FFFC, 1'b0, 5'd2, 32'h100);
        step();
        check("sub_result", alu_result_out, 32'd0);
        check("sub_zero", {31'd0, zero_out}, 32'd1);
        check("sub_btarget", branch_target_out, 32'h0000_00F0);

        single("sra", 4'd10, 32'd4, 32'h8000_0000, 32'hF800_0000);
        single("and", 4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        single("or", 4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
        single("xor", 4'd4, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
        single("nor", 4'd5, 32'd0, 32'd0, 32'hFFFF_FFFF);
        single("slt", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1);
        single("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0);
        single("sll", 4'd8, 32'd31, 32'd1, 32'h8000_0000);
        single("srl", 4'd9, 32'd31, 32'h8000_0000, 32'd1);
        single("op15", 4'd15, 32'd7, 32'd9, 32'd0);

        drive(1'b1, 4'd0, 32'd2, 32'd0, 32'd5, 1'b1, 5'd4, 32'd0);
        step();
        check("imm_add", alu_result_out, 32'd7);

        in_valid = 1'b0;
        step();
        check("idle_valid", {31'd0, valid_out}, 32'd0);
        check("idle_hold", alu_result_out, 32'd7);

        run_iter("mul", 4'd11, 32'h1234_5678, 32'h10, 1'b0, 5'd11, 32'h2345_6780);
        run_iter("divu", 4'd12, 32'd100, 32'd7, 1'b0, 5'd12, 32'd14);
        run_iter("remu", 4'd13, 32'd100, 32'd7, 1'b1, 5'd13, 32'd2);
        run_iter("divu0", 4'd12, 32'd9, 32'd0, 1'b0, 5'd14, 32'hFFFF_FFFF);
        run_iter("remu0", 4'd13, 32'd9, 32'd0, 1'b0, 5'd15, 32'd9);
        in_valid = 1'b0;
        step();
        check("b2b_no_dup", {31'd0, valid_out}, 32'd0);

        // Flush during BUSY
        drive(1'b1, 4'd11, 32'd6, 32'd7, 32'd0, 1'b0, 5'd20, 32'd0);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        settle();
        check("flush_busy_stall", {31'd0, stall}, 32'd1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        settle();
        check("flush_stall_low", {31'd0, stall}, 32'd0);
        check("flush_valid", {31'd0, valid_out}, 32'd0);
        for (int i = 0; i < 35; i++) begin
            step();
            if (valid_out !== 1'b0) check("flush_discard", {31'd0, valid_out}, 32'd0);
        end
        drive(1'b1, 4'd0, 32'd10, 32'd20, 32'd0, 1'b0, 5'd9, 32'd0);
        step();
        check("post_flush_add", alu_result_out, 32'd30);
        check("post_flush_rd", {27'd0, rd_out}, 32'd9);
        check("post_flush_valid", {31'd0, valid_out}, 32'd1);

        // Flush together with a new instruction in IDLE
        drive(1'b1, 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd8, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_idle_valid", {31'd0, valid_out}, 32'd0);
        check("flush_idle_hold", alu_result_out, 32'd30);

        // Reset mid-DIVU
        drive(1'b1, 4'd12, 32'd100, 32'd7, 32'd0, 1'b0, 5'd21, 32'd0);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        settle();
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_valid", {31'd0, valid_out}, 32'd0);
        check("rst_mid_result", alu_result_out, 32'd0);
        check("rst_mid_rd", {27'd0, rd_out}, 32'd0);
        reset = 1'b0;
        drive(1'b1, 4'd0, 32'd3, 32'd4, 32'd0, 1'b0, 5'd5, 32'd0);
        settle();
        check("rst_add_stall", {31'd0, stall}, 32'd0);
        step();
        check("rst_add_result", alu_result_out, 32'd7);
        check("rst_add_rd", {27'd0, rd_out}, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
